// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch stage: credit-limited imem requests, PC-tagged
//            instruction FIFO with registered head, redirect flush/discard.
// Revision : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic [15:0] ins,
    output logic [15:0] ins_pc,
    output logic        ins_valid
);

    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]  CREDITS  = (CNT_W + 1)'(DEPTH);

    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic [15:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [15:0]      ins_q, ins_d;
    logic [15:0]      ins_pc_q, ins_pc_d;
    logic             ins_valid_q, ins_valid_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO occupancy plus in-flight requests never exceeds DEPTH, so a
    // response always finds a free slot.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req    = !rst && !redirect && (credit_used < CREDITS);
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_gnt;
    assign pop         = ins_valid_q && id_ready;
    assign push        = imem_rvalid && (discard_q == '0) && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q + 16'(accept);
        resp_pc_d     = resp_pc_q + 16'(push);
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        discard_d     = discard_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = {imem_rdata, resp_pc_q};
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        // Every response still in flight after this cycle belongs to the old
        // stream and must be dropped.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
        end
    end

    always_comb begin
        ins_valid_d = (count_d != '0);
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        if (count_d != '0) begin
            {ins_d, ins_pc_d} = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ins_q         <= '0;
            ins_pc_q      <= '0;
            ins_valid_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mem_q         <= mem_d;
            ins_q         <= ins_d;
            ins_pc_q      <= ins_pc_d;
            ins_valid_q   <= ins_valid_d;
        end
    end

    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = ins_valid_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (count_q == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Randomized scoreboard bench for if_fetch with an imem model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        ins_valid;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid)
    );

    typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;
    typedef struct { logic [15:0] addr; int ready; bit stale; } req_t;

    exp_t        exp_q[$];
    req_t        memq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          fifo_cnt = 0;
    logic [15:0] model_pc = RESET_PC;
    bit          cur_stale = 0;
    bit          after_rst = 0;
    bit          mon_en = 0;
    int          gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit          hit_mode = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    initial begin
        forever begin
            bit   exp_req;
            int   busy;
            exp_t e;
            @(negedge clk);
            if (mon_en) begin
                if (after_rst) begin
                    chk("rst_ins", ins, 16'h0);
                    chk("rst_ins_pc", ins_pc, 16'h0);
                    chk("rst_addr", imem_addr, RESET_PC);
                end
                busy    = fifo_cnt + memq.size() + (imem_rvalid ? 1 : 0);
                exp_req = !rst && !redirect && (busy < DEPTH);
                chk("imem_req", 16'(imem_req), 16'(exp_req));
                if (imem_req) chk("imem_addr", imem_addr, model_pc);
                chk("ins_valid", 16'(ins_valid), 16'(fifo_cnt > 0));
                if (ins_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_ins: got pc %h, expected no instruction", ins_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ins_pc", ins_pc, e.pc);
                        chk("ins", ins, e.data);
                    end
                end
            end
        end
    end

    // One clock of stimulus plus the reference-model update for that clock.
    task automatic cycle(input logic r, input logic rd, input logic [15:0] rpc);
        req_t cur;
        bit   accept;
        @(posedge clk);
        #1;
        cyc++;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        id_ready    = ($urandom_range(99) < rdy_pct);
        if (!r && memq.size() > 0 && memq[0].ready <= cyc) begin
            cur         = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memf(cur.addr);
            cur_stale   = cur.stale;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
            cur_stale   = 0;
        end
        if (hit_mode && !r && imem_rvalid && fifo_cnt > 0 && id_ready) begin
            redirect    = 1'b1;
            redirect_pc = 16'($urandom);
        end

        @(negedge clk);
        #1;
        accept = imem_req && imem_gnt;
        if (rst) begin
            memq.delete();
            exp_q.delete();
            fifo_cnt  = 0;
            model_pc  = RESET_PC;
            after_rst = 1;
        end else begin
            after_rst = 0;
            if (fifo_cnt > 0 && id_ready) fifo_cnt--;
            if (imem_rvalid && !cur_stale && !redirect) fifo_cnt++;
            if (redirect) begin
                fifo_cnt = 0;
                exp_q.delete();
                foreach (memq[i]) memq[i].stale = 1;
                model_pc = redirect_pc;
            end
            if (accept) begin
                memq.push_back('{addr: imem_addr,
                                 ready: cyc + int'($urandom_range(lat_max, lat_min)),
                                 stale: 1'b0});
                exp_q.push_back('{pc: model_pc, data: memf(model_pc)});
                model_pc = model_pc + 16'd1;
            end
        end
        mon_en = 1;
    endtask

    initial begin
        bit          r, rd;
        logic [15:0] pc;

        repeat (3) cycle(1, 0, 16'h0);

        // Free-running from FFFE across the 16-bit wrap.
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (20) cycle(0, 0, 16'h0);

        // Decoder stall, then release.
        rdy_pct = 0;
        repeat (10) cycle(0, 0, 16'h0);
        rdy_pct = 100;
        repeat (10) cycle(0, 0, 16'h0);

        // Redirect with requests in flight.
        lat_min = 3; lat_max = 3; rdy_pct = 0;
        repeat (6) cycle(0, 0, 16'h0);
        rdy_pct = 100;
        cycle(0, 1, 16'h0040);
        repeat (15) cycle(0, 0, 16'h0);

        // Redirects landing on a response and a pop in the same cycle.
        lat_min = 1; lat_max = 3; gnt_pct = 80; rdy_pct = 60; hit_mode = 1;
        repeat (200) cycle(0, 0, 16'h0);
        hit_mode = 0;

        // Back-to-back redirects.
        cycle(0, 1, 16'h0010);
        cycle(0, 1, 16'h0020);
        repeat (30) cycle(0, 0, 16'h0);

        // Reset mid-stream.
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (5) cycle(0, 0, 16'h0);
        cycle(1, 0, 16'h0);
        repeat (10) cycle(0, 0, 16'h0);

        // Fully random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                rdy_pct = $urandom_range(100, 10);
                lat_max = $urandom_range(3, 1);
            end
            r  = ($urandom_range(199) == 0);
            rd = ($urandom_range(99) < 4);
            pc = ($urandom_range(1) == 1) ? 16'($urandom) : 16'(16'hFFFD + 16'($urandom_range(3)));
            cycle(r, rd, pc);
        end
        repeat (10) cycle(0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
